local_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream sink (collector or router local input) between NUM_PORTS upstream requesters (PEs or router local outputs).
- Takes one packet from the winning requester into a single-entry buffer, then forwards it downstream.
- Uses the same Req/Gnt/Full handshake on both sides as the existing collector.
- Sits between the router local ports and the collector in the mesh testbench.

---
 rtl/local_port_arbiter_pkg.sv | 14 +
 rtl/local_port_arbiter_rr_priority_picker.sv | 28 ++
 rtl/local_port_arbiter.sv | 106 ++++++++++
 tb/tb_local_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_port_arbiter_pkg.sv
// Shared types and defaults for the local port arbiter and its round-robin picker.
package local_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } arbState_t;

    localparam int DEFAULT_NUM_PORTS  = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/local_port_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_priority_picker #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     pointer,
    output logic [PTR_W-1:0]     winner,
    output logic                 valid
);

    logic [PTR_W-1:0] idx;

    // Scan from the farthest offset down so the closest request to the pointer wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int offset = NUM_PORTS - 1; offset >= 0; offset--) begin
            idx = PTR_W'((int'(pointer) + offset) % NUM_PORTS);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/local_port_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS requesters into one downstream sink via a single-entry buffer.
module local_port_arbiter
    import local_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int dataWidth = DEFAULT_DATA_WIDTH,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           ReqUpStr,
    input  logic [NUM_PORTS*dataWidth-1:0] PacketIn,
    output logic [NUM_PORTS-1:0]           GntUpStr,
    output logic [NUM_PORTS-1:0]           UpStrFull,
    output logic                           ReqDnStr,
    output logic [dataWidth-1:0]           PacketOut,
    input  logic                           GntDnStr,
    input  logic                           DnStrFull,
    output logic [PTR_W-1:0]               CurrentOwner,
    output logic [31:0]                    ForwardCount
);

    arbState_t              state, nextState;
    logic [PTR_W-1:0]       pointer, nextPointer;
    logic [PTR_W-1:0]       winner;
    logic                   winValid;
    logic [NUM_PORTS-1:0]   nextGnt, nextFull;
    logic                   nextReqDn;
    logic [dataWidth-1:0]   nextBuffer;
    logic [PTR_W-1:0]       nextOwner;
    logic [31:0]            nextCount;

    rr_priority_picker #(
        .NUM_PORTS(NUM_PORTS),
        .PTR_W    (PTR_W)
    ) picker (
        .req    (ReqUpStr),
        .pointer(pointer),
        .winner (winner),
        .valid  (winValid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // Requests are only sampled in IDLE, so a requester lingering after its grant cannot win twice.
    always_comb begin
        nextState   = state;
        nextPointer = pointer;
        nextGnt     = '0;
        nextReqDn   = ReqDnStr;
        nextBuffer  = PacketOut;
        nextOwner   = CurrentOwner;
        nextCount   = ForwardCount;
        case (state)
            IDLE: begin
                if (winValid) begin
                    nextBuffer      = PacketIn[int'(winner)*dataWidth +: dataWidth];
                    nextGnt[winner] = 1'b1;
                    nextOwner       = winner;
                    nextPointer     = (winner == PTR_W'(NUM_PORTS - 1)) ? '0 : winner + PTR_W'(1);
                    nextState       = HOLD;
                end
            end
            HOLD: begin
                if (!DnStrFull) begin
                    nextReqDn = 1'b1;
                    nextState = SEND;
                end
            end
            SEND: begin
                if (GntDnStr) begin
                    nextReqDn = 1'b0;
                    nextCount = ForwardCount + 32'd1;
                    nextState = RELEASE;
                end
            end
            RELEASE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
        nextFull = {NUM_PORTS{(nextState != IDLE) || DnStrFull}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer      <= '0;
            GntUpStr     <= '0;
            UpStrFull    <= '0;
            ReqDnStr     <= 1'b0;
            PacketOut    <= '0;
            CurrentOwner <= '0;
            ForwardCount <= '0;
        end else begin
            pointer      <= nextPointer;
            GntUpStr     <= nextGnt;
            UpStrFull    <= nextFull;
            ReqDnStr     <= nextReqDn;
            PacketOut    <= nextBuffer;
            CurrentOwner <= nextOwner;
            ForwardCount <= nextCount;
        end
    end

endmodule

// File: tb/tb_local_port_arbiter.sv
// Self-checking bench: requester and sink models drive the arbiter, a queue holds expected deliveries.
module tb_local_port_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    typedef struct {
        int          port;
        logic [31:0] packet;
    } expEntry_t;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     ReqUpStr;
    logic [NP*DW-1:0]  PacketIn;
    logic [NP-1:0]     GntUpStr;
    logic [NP-1:0]     UpStrFull;
    logic              ReqDnStr;
    logic [DW-1:0]     PacketOut;
    logic              GntDnStr;
    logic              DnStrFull;
    logic [1:0]        CurrentOwner;
    logic [31:0]       ForwardCount;

    local_port_arbiter #(.NUM_PORTS(NP), .dataWidth(DW), .PTR_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .ReqUpStr    (ReqUpStr),
        .PacketIn    (PacketIn),
        .GntUpStr    (GntUpStr),
        .UpStrFull   (UpStrFull),
        .ReqDnStr    (ReqDnStr),
        .PacketOut   (PacketOut),
        .GntDnStr    (GntDnStr),
        .DnStrFull   (DnStrFull),
        .CurrentOwner(CurrentOwner),
        .ForwardCount(ForwardCount)
    );

    always #5 clk = ~clk;

    int        assertCount = 0;
    int        failCount   = 0;
    expEntry_t expQ[$];
    int        reqLeft[NP];
    bit        holdExtra[NP];
    bit        dropPending[NP];
    int        seqNum[NP];
    int        expSeq[NP];
    int        cycle = 0;
    int        riseCycle = 0;
    int        deliveries = 0;
    int        gntTotal = 0;
    int        sinkDelay = 0;
    int        sinkWait = 0;
    bit        awaitingGnt = 0;
    bit        dnToggle = 0;
    logic      prevReqDn = 1'b0;
    logic [NP-1:0] prevGnt = '0;
    int        expFwd = 0;
    int        mark;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    function automatic logic [31:0] pkt(input int port, input int s);
        return {16'hA5A5, 8'(s), 8'(port + 1)};
    endfunction

    task automatic pushExpect(input int port);
        expEntry_t e;
        e.port   = port;
        e.packet = pkt(port, expSeq[port]);
        expSeq[port]++;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int port, input int count, input bit extra);
        reqLeft[port]            = count;
        holdExtra[port]          = extra;
        ReqUpStr[port]           = 1'b1;
        PacketIn[port*DW +: DW]  = pkt(port, seqNum[port]);
    endtask

    task automatic advancePort(input int i);
        reqLeft[i]--;
        seqNum[i]++;
        if (reqLeft[i] > 0) begin
            ReqUpStr[i]        = 1'b1;
            PacketIn[i*DW +: DW] = pkt(i, seqNum[i]);
        end else begin
            ReqUpStr[i] = 1'b0;
        end
    endtask

    // One cycle of the requester and sink models, sampled at the falling edge.
    task automatic step();
        @(negedge clk);
        cycle++;
        GntDnStr = 1'b0;
        if (ReqDnStr && !prevReqDn) riseCycle = cycle;
        if (GntUpStr != '0) begin
            gntTotal++;
            checkOutput("gntPulse", prevGnt, '0);
            if (expQ.size() > 0) checkOutput("gntOwner", GntUpStr, NP'(1) << expQ[0].port);
            else                 checkOutput("gntUnexpected", GntUpStr, '0);
        end
        if (awaitingGnt) begin
            checkOutput("reqHeld", ReqDnStr, 1);
            if (expQ.size() > 0) checkOutput("pktStable", PacketOut, expQ[0].packet);
        end
        if (ReqDnStr) begin
            if (sinkWait >= sinkDelay) begin
                GntDnStr    = 1'b1;
                sinkWait    = 0;
                awaitingGnt = 0;
                deliveries++;
                if (expQ.size() > 0) begin
                    checkOutput("pktOut", PacketOut, expQ[0].packet);
                    checkOutput("owner", CurrentOwner, expQ[0].port);
                    void'(expQ.pop_front());
                end else begin
                    checkOutput("unexpDeliver", 1, 0);
                end
            end else begin
                sinkWait++;
                awaitingGnt = 1;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (dropPending[i]) begin
                dropPending[i] = 0;
                advancePort(i);
            end
            if (GntUpStr[i]) begin
                if (holdExtra[i]) begin
                    holdExtra[i]   = 0;
                    dropPending[i] = 1;
                end else begin
                    advancePort(i);
                end
            end
        end
        if (dnToggle) DnStrFull = ~DnStrFull;
        prevReqDn = ReqDnStr;
        prevGnt   = GntUpStr;
    endtask

    task automatic waitDeliveries(input int target, input int budget, input string tag);
        int n = 0;
        while (deliveries < target && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, deliveries, target);
    endtask

    task automatic doReset();
        reset = 1'b0;
        expQ.delete();
        awaitingGnt = 0;
        sinkWait    = 0;
        prevReqDn   = 1'b0;
        prevGnt     = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        clk = 0; reset = 0; ReqUpStr = '0; PacketIn = '0; GntDnStr = 0; DnStrFull = 0;
        for (int i = 0; i < NP; i++) begin
            reqLeft[i] = 0; holdExtra[i] = 0; dropPending[i] = 0; seqNum[i] = 0; expSeq[i] = 0;
        end
        #1;
        checkOutput("rstReqDn", ReqDnStr, 0);
        checkOutput("rstGnt", GntUpStr, 0);
        checkOutput("rstFull", UpStrFull, 0);
        checkOutput("rstPkt", PacketOut, 0);
        checkOutput("rstOwner", CurrentOwner, 0);
        checkOutput("rstCount", ForwardCount, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        step();

        // Single request on port 2, collector-style sink
        mark = cycle;
        applyStimulus(2, 1, 0);
        pushExpect(2);
        waitDeliveries(1, 20, "t1Deliver");
        checkOutput("t1Latency", riseCycle - mark, 2);
        repeat (4) step();
        checkOutput("t1HoldLast", PacketOut, 32'hA5A5_0003);
        checkOutput("t1Count", ForwardCount, 1);

        // All ports requesting from pointer 0
        doReset();
        deliveries = 0;
        step();
        applyStimulus(0, 2, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(2, 1, 0);
        applyStimulus(3, 1, 0);
        pushExpect(0); pushExpect(1); pushExpect(2); pushExpect(3); pushExpect(0);
        waitDeliveries(5, 40, "t2Deliver");
        repeat (2) step();
        checkOutput("t2Count", ForwardCount, 5);
        expFwd = 5;

        // Downstream busy holds the FSM in HOLD
        DnStrFull = 1;
        step();
        checkOutput("idleFullBusy", UpStrFull, 4'hF);
        DnStrFull = 0;
        step();
        checkOutput("idleFullFree", UpStrFull, 4'h0);
        applyStimulus(1, 1, 0);
        pushExpect(1);
        step();
        DnStrFull = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            checkOutput("t3NoReq", ReqDnStr, 0);
            checkOutput("t3Full", UpStrFull, 4'hF);
        end
        DnStrFull = 0;
        mark = cycle;
        step();
        checkOutput("t3Rise", riseCycle - mark, 1);
        waitDeliveries(6, 10, "t3Deliver");
        expFwd++;

        // Slow sink with toggling DnStrFull
        sinkDelay = 7;
        dnToggle  = 1;
        applyStimulus(2, 1, 0);
        pushExpect(2);
        waitDeliveries(7, 40, "t4Deliver");
        dnToggle  = 0;
        DnStrFull = 0;
        sinkDelay = 0;
        repeat (3) step();
        expFwd++;
        checkOutput("t4Count", ForwardCount, expFwd);

        // Requester holds Req one extra cycle after its grant
        mark = gntTotal;
        applyStimulus(0, 1, 1);
        pushExpect(0);
        waitDeliveries(8, 20, "t6Deliver");
        repeat (8) step();
        expFwd++;
        checkOutput("t6Grants", gntTotal - mark, 1);
        checkOutput("t6Count", ForwardCount, expFwd);

        // Reset while in SEND drops the packet
        sinkDelay = 20;
        applyStimulus(1, 1, 0);
        pushExpect(1);
        begin
            int n = 0;
            while (!awaitingGnt && n < 10) begin
                step();
                n++;
            end
        end
        checkOutput("t5InSend", awaitingGnt, 1);
        #2 reset = 0;
        #1;
        checkOutput("t5ReqDn", ReqDnStr, 0);
        checkOutput("t5Gnt", GntUpStr, 0);
        checkOutput("t5Count", ForwardCount, 0);
        checkOutput("t5Owner", CurrentOwner, 0);
        doReset();
        sinkDelay  = 0;
        deliveries = 0;
        step();
        applyStimulus(3, 1, 0);
        pushExpect(3);
        waitDeliveries(1, 20, "t5Deliver");
        repeat (2) step();
        checkOutput("t5After", ForwardCount, 1);
        checkOutput("t5QueueEmpty", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
